hanoi_move_checker: RTL and testbench

HANOI_MOVE_CHECKER -- requirements
Module: hanoi_move_checker

---
 rtl/hanoi_move_checker.sv | 136 +++++++++++++
 tb/tb_hanoi_move_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hanoi_move_checker.sv
// Tower-of-Hanoi move legality checker.
// Tracks the peg of every disk, accepts one move at a time, then checks and
// applies it in a single evaluation cycle. Done and error are absorbing
// until reset.
module hanoi_move_checker #(
  parameter int         NDISKS     = 5,
  parameter logic [1:0] START_PEG  = 2'd1,
  parameter logic [1:0] TARGET_PEG = 2'd3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_valid,
  input  logic [1:0]        from_peg,
  input  logic [1:0]        to_peg,
  output logic              move_ready,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [NDISKS:0]   move_count,
  output logic [2:0]        last_disk
);

  localparam int CW = NDISKS + 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic [1:0]      loc_q [NDISKS];
  logic [1:0]      loc_d [NDISKS];
  logic [1:0]      from_q, from_d;
  logic [1:0]      to_q, to_d;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      last_q, last_d;

  logic            src_found, dst_found;
  logic [2:0]      src_idx, dst_idx;
  logic            all_tgt_q, all_tgt_mv;

  // Smallest disk on the source/destination pegs (lowest index wins) and
  // whether every disk sits on the target peg now / after the pending move.
  always_comb begin
    src_found  = 1'b0;
    dst_found  = 1'b0;
    src_idx    = '0;
    dst_idx    = '0;
    all_tgt_q  = 1'b1;
    all_tgt_mv = 1'b1;
    for (int unsigned i = 0; i < NDISKS; i++) begin
      if (!src_found && loc_q[i] == from_q) begin
        src_found = 1'b1;
        src_idx   = 3'(i);
      end
      if (!dst_found && loc_q[i] == to_q) begin
        dst_found = 1'b1;
        dst_idx   = 3'(i);
      end
      if (loc_q[i] != TARGET_PEG) all_tgt_q = 1'b0;
    end
    for (int unsigned i = 0; i < NDISKS; i++) begin
      if (((3'(i) == src_idx) ? to_q : loc_q[i]) != TARGET_PEG) all_tgt_mv = 1'b0;
    end
  end

  // Next-state logic: accept in IDLE, check and apply in EVAL.
  always_comb begin
    state_d = state_q;
    loc_d   = loc_q;
    from_d  = from_q;
    to_d    = to_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (all_tgt_q) begin
          state_d = DONE;
        end else if (move_valid) begin
          from_d  = from_peg;
          to_d    = to_peg;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (from_q == 2'd0 || to_q == 2'd0 || from_q == to_q) begin
          err_d   = 2'b01;
          state_d = ERR;
        end else if (!src_found) begin
          err_d   = 2'b10;
          state_d = ERR;
        end else if (dst_found && dst_idx < src_idx) begin
          err_d   = 2'b11;
          state_d = ERR;
        end else begin
          for (int unsigned i = 0; i < NDISKS; i++) begin
            if (3'(i) == src_idx) loc_d[i] = to_q;
          end
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
          last_d  = src_idx;
          state_d = all_tgt_mv ? DONE : IDLE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NDISKS; i++) loc_q[i] <= START_PEG;
      from_q  <= '0;
      to_q    <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      loc_q   <= loc_d;
      from_q  <= from_d;
      to_q    <= to_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // A solved puzzle sitting in IDLE (start peg equals target) must not take a move.
  assign move_ready = (state_q == IDLE) && !all_tgt_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign err_code   = err_q;
  assign move_count = cnt_q;
  assign last_disk  = last_q;

endmodule

// File: tb/tb_hanoi_move_checker.sv
// Directed bench for hanoi_move_checker: 3-disk vector table, 5-disk
// streaming solution, reset-in-EVAL and start==target corner cases.
module tb_hanoi_move_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 3-disk instance
  logic       r3 = 1'b1, v3 = 1'b0, rdy3, done3, err3;
  logic [1:0] f3 = '0, t3 = '0, code3;
  logic [3:0] cnt3;
  logic [2:0] last3;

  // default 5-disk instance
  logic       r5 = 1'b1, v5 = 1'b0, rdy5, done5, err5;
  logic [1:0] f5 = '0, t5 = '0, code5;
  logic [5:0] cnt5;
  logic [2:0] last5;

  // start peg equals target peg
  logic       rS = 1'b1, vS = 1'b0, rdyS, doneS, errS;
  logic [1:0] fS = '0, tS = '0, codeS;
  logic [2:0] cntS;
  logic [2:0] lastS;

  hanoi_move_checker #(.NDISKS(3)) dut3 (
    .clk(clk), .reset(r3), .move_valid(v3), .from_peg(f3), .to_peg(t3),
    .move_ready(rdy3), .done(done3), .error(err3), .err_code(code3),
    .move_count(cnt3), .last_disk(last3));

  hanoi_move_checker dut5 (
    .clk(clk), .reset(r5), .move_valid(v5), .from_peg(f5), .to_peg(t5),
    .move_ready(rdy5), .done(done5), .error(err5), .err_code(code5),
    .move_count(cnt5), .last_disk(last5));

  hanoi_move_checker #(.NDISKS(2), .START_PEG(2'd2), .TARGET_PEG(2'd2)) dutS (
    .clk(clk), .reset(rS), .move_valid(vS), .from_peg(fS), .to_peg(tS),
    .move_ready(rdyS), .done(doneS), .error(errS), .err_code(codeS),
    .move_count(cntS), .last_disk(lastS));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset3();
    @(negedge clk); r3 = 1'b1; v3 = 1'b0;
    @(negedge clk); r3 = 1'b0;
  endtask

  // Waits (bounded) for ready, presents one move for one cycle, returns
  // at the negedge after the evaluation edge.
  task automatic move3(input logic [1:0] f, input logic [1:0] t);
    int n = 0;
    while (!rdy3 && n < 8) begin @(negedge clk); n++; end
    chk("ready_before_move", int'(rdy3), 1);
    v3 = 1'b1; f3 = f; t3 = t;
    @(negedge clk);
    chk("ready_in_eval", int'(rdy3), 0);
    v3 = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] f;
    logic [1:0] t;
    bit         e_done;
    bit         e_err;
    logic [1:0] e_code;
    int         e_cnt;
    int         e_last;
  } vec_t;

  vec_t vecs[13];

  // 5-disk reference model
  logic [1:0] pos5 [5];

  function automatic int ctz(input int m);
    int k = 0;
    while (m[k] == 1'b0 && k < 31) k++;
    return k;
  endfunction

  // Optimal solution: move m moves disk ctz(m); disks with odd (n-k)
  // cycle 1->3->2->1, the others 1->2->3->1.
  task automatic next5(input int m, output logic [1:0] f, output logic [1:0] t,
                       output int k);
    k = ctz(m);
    f = pos5[k];
    if (((5 - k) % 2) == 1) t = (f == 2'd1) ? 2'd3 : f - 2'd1;
    else                    t = (f == 2'd3) ? 2'd1 : f + 2'd1;
    pos5[k] = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cur_k, nxt_k;
    logic [1:0] nf, nt;

    vecs[0]  = '{0, 2'd1, 2'd3, 0, 0, 2'd0, 1, 0};
    vecs[1]  = '{0, 2'd1, 2'd2, 0, 0, 2'd0, 2, 1};
    vecs[2]  = '{0, 2'd3, 2'd2, 0, 0, 2'd0, 3, 0};
    vecs[3]  = '{0, 2'd1, 2'd3, 0, 0, 2'd0, 4, 2};
    vecs[4]  = '{0, 2'd2, 2'd1, 0, 0, 2'd0, 5, 0};
    vecs[5]  = '{0, 2'd2, 2'd3, 0, 0, 2'd0, 6, 1};
    vecs[6]  = '{0, 2'd1, 2'd3, 1, 0, 2'd0, 7, 0};
    vecs[7]  = '{1, 2'd1, 2'd2, 0, 0, 2'd0, 1, 0};
    vecs[8]  = '{0, 2'd1, 2'd2, 0, 1, 2'd3, 1, 0};
    vecs[9]  = '{1, 2'd2, 2'd3, 0, 1, 2'd2, 0, 0};
    vecs[10] = '{1, 2'd1, 2'd1, 0, 1, 2'd1, 0, 0};
    vecs[11] = '{1, 2'd0, 2'd2, 0, 1, 2'd1, 0, 0};
    vecs[12] = '{1, 2'd3, 2'd1, 0, 1, 2'd2, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    r3 = 1'b0; r5 = 1'b0; rS = 1'b0;
    chk("rst_ready", int'(rdy3), 1);
    chk("rst_done", int'(done3), 0);
    chk("rst_error", int'(err3), 0);
    chk("rst_code", int'(code3), 0);
    chk("rst_count", int'(cnt3), 0);
    chk("rst_last", int'(last3), 0);

    // Start peg equals target: done one cycle after reset release
    @(negedge clk);
    chk("same_peg_done", int'(doneS), 1);
    chk("same_peg_count", int'(cntS), 0);
    chk("same_peg_ready", int'(rdyS), 0);

    // Table-driven 3-disk vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) reset3();
      move3(vecs[i].f, vecs[i].t);
      chk($sformatf("v%0d_done", i), int'(done3), int'(vecs[i].e_done));
      chk($sformatf("v%0d_error", i), int'(err3), int'(vecs[i].e_err));
      chk($sformatf("v%0d_code", i), int'(code3), int'(vecs[i].e_code));
      chk($sformatf("v%0d_count", i), int'(cnt3), vecs[i].e_cnt);
      chk($sformatf("v%0d_last", i), int'(last3), vecs[i].e_last);
      if (vecs[i].e_done || vecs[i].e_err) begin
        // Absorbing: further moves neither accepted nor counted
        v3 = 1'b1; f3 = 2'd3; t3 = 2'd1;
        repeat (3) @(negedge clk);
        v3 = 1'b0;
        chk($sformatf("v%0d_hold_ready", i), int'(rdy3), 0);
        chk($sformatf("v%0d_hold_count", i), int'(cnt3), vecs[i].e_cnt);
        chk($sformatf("v%0d_hold_done", i), int'(done3), int'(vecs[i].e_done));
        chk($sformatf("v%0d_hold_error", i), int'(err3), int'(vecs[i].e_err));
      end
    end

    // Reset asserted during EVAL of 1->3 discards the move
    reset3();
    v3 = 1'b1; f3 = 2'd1; t3 = 2'd3;
    @(negedge clk);
    chk("reval_in_eval", int'(rdy3), 0);
    v3 = 1'b0; r3 = 1'b1;
    @(negedge clk);
    r3 = 1'b0;
    @(negedge clk);
    chk("reval_ready", int'(rdy3), 1);
    chk("reval_count", int'(cnt3), 0);
    chk("reval_error", int'(err3), 0);
    move3(2'd3, 2'd1);
    chk("reval_peg3_empty", int'(code3), 2);
    reset3();
    move3(2'd2, 2'd1);
    chk("reval_peg2_empty", int'(code3), 2);
    reset3();
    move3(2'd1, 2'd3);
    chk("reval_legal_count", int'(cnt3), 1);
    chk("reval_legal_last", int'(last3), 0);
    move3(2'd1, 2'd2);
    chk("reval_disk1_last", int'(last3), 1);
    chk("reval_disk1_error", int'(err3), 0);

    // 5-disk solution with move_valid held high throughout
    for (int i = 0; i < 5; i++) pos5[i] = 2'd1;
    @(negedge clk); r5 = 1'b1;
    @(negedge clk); r5 = 1'b0;
    next5(1, nf, nt, cur_k);
    f5 = nf; t5 = nt; v5 = 1'b1;
    for (int m = 1; m <= 31; m++) begin
      @(negedge clk);
      chk($sformatf("m%0d_eval_ready", m), int'(rdy5), 0);
      chk($sformatf("m%0d_eval_count", m), int'(cnt5), m - 1);
      nxt_k = 0;
      if (m < 31) begin
        next5(m + 1, nf, nt, nxt_k);
        f5 = nf; t5 = nt;
      end else begin
        f5 = 2'd3; t5 = 2'd1;
      end
      @(negedge clk);
      chk($sformatf("m%0d_count", m), int'(cnt5), m);
      chk($sformatf("m%0d_last", m), int'(last5), cur_k);
      chk($sformatf("m%0d_error", m), int'(err5), 0);
      chk($sformatf("m%0d_done", m), int'(done5), (m == 31) ? 1 : 0);
      cur_k = nxt_k;
    end
    repeat (4) @(negedge clk);
    v5 = 1'b0;
    chk("n5_final_count", int'(cnt5), 31);
    chk("n5_final_done", int'(done5), 1);
    chk("n5_final_ready", int'(rdy5), 0);
    chk("n5_final_error", int'(err5), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
